// File: rtl/avs_sample_buffer_pkg.sv
// Shared types and constants for the Avalon-MM sample buffer.
package avs_sample_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    typedef struct packed {
        logic rd;
        logic wr;
    } req_t;

    localparam int REG_STATUS = 0;
    localparam int REG_CLEAR  = 1;

    // Address bit that selects the register window over the RAM.
    function automatic int region_bit(input int depth_log2);
        return depth_log2 + 2;
    endfunction

endpackage

// File: rtl/sample_buffer_ram.sv
// Simple dual-port RAM: port A read/byte-write, port B fill write; port A wins collisions.
module sample_buffer_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] a_addr,
    input  logic [3:0]    a_we,
    input  logic [31:0]   a_wdata,
    output logic [31:0]   a_rdata,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [31:0]   b_wdata
);

    logic [31:0] mem [2**AW];

    // Port A lanes are written after port B so they override on the same word.
    always_ff @(posedge clk) begin
        if (b_we)
            mem[b_addr] <= b_wdata;
        for (int i = 0; i < 4; i++)
            if (a_we[i])
                mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
    end

    assign a_rdata = mem[a_addr];

endmodule

// File: rtl/avs_sample_buffer.sv
// Avalon-MM slave sample buffer with fixed wait states and a fill port.
// Optional byte lanes: define AVS_SAMPLE_BUFFER_BYTEENABLE_EN.
module avs_sample_buffer
    import avs_sample_buffer_pkg::*;
#(
    parameter int AVS_AVALONSLAVE_DATA_WIDTH    = 32,
    parameter int AVS_AVALONSLAVE_ADDRESS_WIDTH = 32,
    parameter int DEPTH_LOG2                    = 10,
    parameter int WAIT_CYCLES                   = 2
) (
    input  logic                                     CSI_CLOCK_CLK,
    input  logic                                     CSI_CLOCK_RESET,
    input  logic [AVS_AVALONSLAVE_ADDRESS_WIDTH-1:0] AVS_AVALONSLAVE_ADDRESS,
    input  logic                                     AVS_AVALONSLAVE_READ,
    input  logic                                     AVS_AVALONSLAVE_WRITE,
    input  logic [31:0]                              AVS_AVALONSLAVE_WRITEDATA,
`ifdef AVS_SAMPLE_BUFFER_BYTEENABLE_EN
    input  logic [3:0]                               AVS_AVALONSLAVE_BYTEENABLE,
`endif
    output logic [31:0]                              AVS_AVALONSLAVE_READDATA,
    output logic                                     AVS_AVALONSLAVE_WAITREQUEST,
    input  logic                                     SAMPLE_VALID,
    input  logic [31:0]                              SAMPLE_DATA,
    output logic                                     PROTOCOL_ERR
);

    localparam int RB = region_bit(DEPTH_LOG2);

    state_e                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    req_t                  req_q;
    logic [DEPTH_LOG2-1:0] idx, wr_ptr;
    logic                  wrap, reg_sel, oor, req, both;
    logic                  wr_commit, clr;
    logic [3:0]            be, ram_we;
    logic [31:0]           ram_rdata, status, rd_value;
    logic                  unused_addr;

`ifdef AVS_SAMPLE_BUFFER_BYTEENABLE_EN
    assign be = AVS_AVALONSLAVE_BYTEENABLE;
`else
    assign be = 4'hF;
`endif

    assign idx         = AVS_AVALONSLAVE_ADDRESS[DEPTH_LOG2+1:2];
    assign reg_sel     = AVS_AVALONSLAVE_ADDRESS[RB];
    assign oor         = (AVS_AVALONSLAVE_ADDRESS >> (RB + 1)) != '0;
    assign unused_addr = ^AVS_AVALONSLAVE_ADDRESS[1:0];
    assign req         = AVS_AVALONSLAVE_READ | AVS_AVALONSLAVE_WRITE;
    assign both        = AVS_AVALONSLAVE_READ & AVS_AVALONSLAVE_WRITE;
    assign status      = {wrap, {(31-DEPTH_LOG2){1'b0}}, wr_ptr};

    always_comb begin
        rd_value = '0;
        if (!oor) begin
            if (!reg_sel)
                rd_value = ram_rdata;
            else if (idx == DEPTH_LOG2'(REG_STATUS))
                rd_value = status;
        end
    end

    always_ff @(posedge CSI_CLOCK_CLK or negedge CSI_CLOCK_RESET) begin
        if (!CSI_CLOCK_RESET) begin
            state                    <= ST_IDLE;
            cnt                      <= '0;
            req_q                    <= '0;
            AVS_AVALONSLAVE_READDATA <= '0;
            PROTOCOL_ERR             <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == ST_IDLE && req)
                req_q <= '{rd: AVS_AVALONSLAVE_READ, wr: AVS_AVALONSLAVE_WRITE};
            // Data is sampled in the last stall cycle so it is stable through accept.
            if (state_nxt == ST_ACK)
                AVS_AVALONSLAVE_READDATA <= (AVS_AVALONSLAVE_READ && !AVS_AVALONSLAVE_WRITE) ? rd_value : '0;
            if ((state == ST_IDLE && both) || (state == ST_WAIT && !req))
                PROTOCOL_ERR <= 1'b1;
        end
    end

    // cnt holds the stall cycles still owed, counting the current one.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: if (req) begin
                cnt_nxt   = 4'(WAIT_CYCLES - 1);
                state_nxt = (WAIT_CYCLES == 1) ? ST_ACK : ST_WAIT;
            end
            ST_WAIT: begin
                if (!req)
                    state_nxt = ST_IDLE;
                else if (cnt <= 4'd1)
                    state_nxt = ST_ACK;
                else
                    cnt_nxt = cnt - 4'd1;
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        AVS_AVALONSLAVE_WAITREQUEST = req & (state != ST_ACK);
        wr_commit = (state == ST_ACK) & req_q.wr & ~req_q.rd & AVS_AVALONSLAVE_WRITE & ~oor;
        ram_we    = (wr_commit & ~reg_sel) ? be : 4'h0;
        clr       = wr_commit & reg_sel & (idx == DEPTH_LOG2'(REG_CLEAR));
    end

    // CLEAR beats a concurrent fill; the sample still lands at the old pointer.
    always_ff @(posedge CSI_CLOCK_CLK or negedge CSI_CLOCK_RESET) begin
        if (!CSI_CLOCK_RESET) begin
            wr_ptr <= '0;
            wrap   <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            wrap   <= 1'b0;
        end else if (SAMPLE_VALID) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (&wr_ptr)
                wrap <= 1'b1;
        end
    end

    sample_buffer_ram #(.AW(DEPTH_LOG2)) u_ram (
        .clk     (CSI_CLOCK_CLK),
        .a_addr  (idx),
        .a_we    (ram_we),
        .a_wdata (AVS_AVALONSLAVE_WRITEDATA),
        .a_rdata (ram_rdata),
        .b_we    (SAMPLE_VALID),
        .b_addr  (wr_ptr),
        .b_wdata (SAMPLE_DATA)
    );

endmodule

// File: tb/tb_avs_sample_buffer.sv
// Randomized self-checking bench for avs_sample_buffer against a word-level model.
module tb_avs_sample_buffer;

    localparam int DL    = 10;
    localparam int DEPTH = 1 << DL;
    localparam int WC    = 2;
    localparam logic [31:0] REG_BASE = 32'(4 * DEPTH);

    logic        clk, rst_n;
    logic [31:0] addr, wdata, rdata_o, sdata;
    logic        rd, wr, waitreq, svalid, perr;
    logic [3:0]  be_sig;

    int total = 0;
    int bad   = 0;

    logic [31:0] mm [DEPTH];
    bit          mv [DEPTH];
    int          mptr;
    bit          mwrap;
    int          wq[$];

    avs_sample_buffer #(.DEPTH_LOG2(DL), .WAIT_CYCLES(WC)) dut (
        .CSI_CLOCK_CLK               (clk),
        .CSI_CLOCK_RESET             (rst_n),
        .AVS_AVALONSLAVE_ADDRESS     (addr),
        .AVS_AVALONSLAVE_READ        (rd),
        .AVS_AVALONSLAVE_WRITE       (wr),
        .AVS_AVALONSLAVE_WRITEDATA   (wdata),
`ifdef AVS_SAMPLE_BUFFER_BYTEENABLE_EN
        .AVS_AVALONSLAVE_BYTEENABLE  (be_sig),
`endif
        .AVS_AVALONSLAVE_READDATA    (rdata_o),
        .AVS_AVALONSLAVE_WAITREQUEST (waitreq),
        .SAMPLE_VALID                (svalid),
        .SAMPLE_DATA                 (sdata),
        .PROTOCOL_ERR                (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_read(input logic [31:0] a);
        int w;
        w = int'(a >> 2);
        if (w >= 2 * DEPTH) return 32'h0;
        if (w >= DEPTH) return (w == DEPTH) ? ((32'(mwrap) << 31) | 32'(mptr)) : 32'h0;
        return mm[w];
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        int w;
        w = int'(a >> 2);
        if (w >= 2 * DEPTH) return;
        if (w >= DEPTH) begin
            if (w == DEPTH + 1) begin mptr = 0; mwrap = 0; end
            return;
        end
        for (int i = 0; i < 4; i++)
            if (b[i]) mm[w][8*i +: 8] = d[8*i +: 8];
        if (!mv[w]) begin mv[w] = 1; wq.push_back(w); end
    endtask

    task automatic m_fill(input logic [31:0] d);
        mm[mptr] = d;
        if (!mv[mptr]) begin mv[mptr] = 1; wq.push_back(mptr); end
        mptr = (mptr + 1) % DEPTH;
        if (mptr == 0) mwrap = 1;
    endtask

    // ---------------- drivers ----------------
    // Called 1 time unit after a rising edge; returns 1 time unit after the commit edge.
    task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input bit fill_acc, input logic [31:0] fd,
                          output int waits, output logic [31:0] rdat, output bit to);
        rd = r; wr = w; addr = a; wdata = d; be_sig = b;
        waits = 0; to = 1; rdat = 'x;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (waitreq === 1'b0) begin
                rdat = rdata_o;
                to   = 0;
                if (fill_acc) begin svalid = 1; sdata = fd; end
                break;
            end
            waits++;
        end
        @(posedge clk); #1;
        rd = 0; wr = 0; svalid = 0;
    endtask

    task automatic fill_one(input logic [31:0] d);
        svalid = 1; sdata = d;
        @(posedge clk); #1;
        svalid = 0;
        m_fill(d);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 0; rd = 0; wr = 0; svalid = 0; addr = 0; wdata = 0; sdata = 0; be_sig = 4'hF;
        mptr = 0; mwrap = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (waitreq !== 1'b0) begin bad++; $display("FAIL reset_waitreq got=%b exp=0", waitreq); end
        total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%h exp=0", rdata_o); end
        total++; if (perr !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", perr); end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int n; logic [31:0] r; bit to;
        access(0, 1, 32'h10, 32'h12345678, 4'hF, 0, 0, n, r, to);
        m_write(32'h10, 32'h12345678, 4'hF);
        total++; if (to || n != WC) begin bad++; $display("FAIL basic_wr_waits got=%0d exp=%0d to=%0b", n, WC, to); end
        access(1, 0, 32'h10, 0, 4'hF, 0, 0, n, r, to);
        total++; if (to || n != WC) begin bad++; $display("FAIL basic_rd_waits got=%0d exp=%0d to=%0b", n, WC, to); end
        total++; if (r !== 32'h12345678) begin bad++; $display("FAIL basic_rd_data got=%h exp=12345678", r); end
        access(0, 1, 32'h20, 32'hCAFEF00D, 4'hF, 0, 0, n, r, to);
        m_write(32'h20, 32'hCAFEF00D, 4'hF);
        access(0, 1, 32'h24, 32'h0BADBEEF, 4'hF, 0, 0, n, r, to);
        m_write(32'h24, 32'h0BADBEEF, 4'hF);
    endtask

    task automatic test_random;
        int n, w; logic [31:0] r, d, exp; bit to;
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(2))
                0: begin
                    w = $urandom_range(DEPTH - 1); d = $urandom;
                    access(0, 1, 32'(w) << 2, d, 4'hF, 0, 0, n, r, to);
                    m_write(32'(w) << 2, d, 4'hF);
                    total++; if (to || n != WC) begin bad++; $display("FAIL rand_wr_waits it=%0d got=%0d exp=%0d", it, n, WC); end
                end
                1: begin
                    w = wq[$urandom_range(wq.size() - 1)];
                    exp = m_read(32'(w) << 2);
                    access(1, 0, 32'(w) << 2, 0, 4'hF, 0, 0, n, r, to);
                    total++; if (to || n != WC || r !== exp) begin bad++; $display("FAIL rand_rd it=%0d word=%0d got=%h exp=%h waits=%0d", it, w, r, exp, n); end
                end
                default: fill_one($urandom);
            endcase
        end
        exp = m_read(REG_BASE);
        access(1, 0, REG_BASE, 0, 4'hF, 0, 0, n, r, to);
        total++; if (r !== exp) begin bad++; $display("FAIL rand_status got=%h exp=%h", r, exp); end
    endtask

    task automatic test_fill_wrap;
        int n, w; logic [31:0] r, d, exp; bit to;
        access(0, 1, REG_BASE + 4, 32'h1, 4'hF, 0, 0, n, r, to);
        m_write(REG_BASE + 4, 32'h1, 4'hF);
        svalid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom; sdata = d;
            @(posedge clk); #1;
            m_fill(d);
        end
        svalid = 0;
        access(1, 0, REG_BASE, 0, 4'hF, 0, 0, n, r, to);
        total++; if (r !== 32'h80000000 || r !== m_read(REG_BASE)) begin bad++; $display("FAIL wrap_status got=%h exp=80000000", r); end
        w = $urandom_range(DEPTH - 1); exp = m_read(32'(w) << 2);
        access(1, 0, 32'(w) << 2, 0, 4'hF, 0, 0, n, r, to);
        total++; if (r !== exp) begin bad++; $display("FAIL wrap_word word=%0d got=%h exp=%h", w, r, exp); end
        access(0, 1, REG_BASE + 4, 32'h0, 4'hF, 0, 0, n, r, to);
        m_write(REG_BASE + 4, 32'h0, 4'hF);
        access(1, 0, REG_BASE, 0, 4'hF, 0, 0, n, r, to);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL clear_status got=%h exp=0", r); end
        access(1, 0, REG_BASE + 4, 0, 4'hF, 0, 0, n, r, to);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL clear_reg_read got=%h exp=0", r); end
    endtask

    task automatic test_collision;
        int n, w; logic [31:0] r, fd, exp; bit to;
        repeat (5) fill_one($urandom);
        w = mptr; fd = $urandom;
        access(0, 1, 32'(w) << 2, 32'hAAAA5555, 4'hF, 1, fd, n, r, to);
        m_fill(fd); m_write(32'(w) << 2, 32'hAAAA5555, 4'hF);
        access(1, 0, 32'(w) << 2, 0, 4'hF, 0, 0, n, r, to);
        total++; if (r !== 32'hAAAA5555) begin bad++; $display("FAIL collide_word got=%h exp=aaaa5555", r); end
        exp = m_read(REG_BASE);
        access(1, 0, REG_BASE, 0, 4'hF, 0, 0, n, r, to);
        total++; if (r !== exp) begin bad++; $display("FAIL collide_ptr got=%h exp=%h", r, exp); end
        w = mptr; fd = $urandom;
        access(0, 1, REG_BASE + 4, 32'h0, 4'hF, 1, fd, n, r, to);
        m_fill(fd); m_write(REG_BASE + 4, 32'h0, 4'hF);
        access(1, 0, REG_BASE, 0, 4'hF, 0, 0, n, r, to);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL clear_fill_status got=%h exp=0", r); end
        access(1, 0, 32'(w) << 2, 0, 4'hF, 0, 0, n, r, to);
        total++; if (r !== fd) begin bad++; $display("FAIL clear_fill_word got=%h exp=%h", r, fd); end
    endtask

    task automatic test_oor;
        int n; logic [31:0] r, exp; bit to;
        access(0, 1, 32'h0000_2010, 32'hDEADDEAD, 4'hF, 0, 0, n, r, to);
        access(0, 1, 32'h8000_0010, 32'hDEADDEAD, 4'hF, 0, 0, n, r, to);
        exp = m_read(32'h10);
        access(1, 0, 32'h10, 0, 4'hF, 0, 0, n, r, to);
        total++; if (r !== exp) begin bad++; $display("FAIL oor_nowrite got=%h exp=%h", r, exp); end
        access(1, 0, 32'h0000_2010, 0, 4'hF, 0, 0, n, r, to);
        total++; if (to || n != WC || r !== 32'h0) begin bad++; $display("FAIL oor_read got=%h exp=0 waits=%0d", r, n); end
        access(1, 0, REG_BASE + 20, 0, 4'hF, 0, 0, n, r, to);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL reg_other got=%h exp=0", r); end
        total++; if (perr !== 1'b0) begin bad++; $display("FAIL oor_perr got=%b exp=0", perr); end
    endtask

    task automatic test_both;
        int n; logic [31:0] r, exp; bit to;
        exp = m_read(32'h10);
        access(1, 1, 32'h10, 32'h55555555, 4'hF, 0, 0, n, r, to);
        total++; if (to || n != WC || r !== 32'h0) begin bad++; $display("FAIL both_access got=%h waits=%0d exp=0 waits=%0d", r, n, WC); end
        total++; if (perr !== 1'b1) begin bad++; $display("FAIL both_perr got=%b exp=1", perr); end
        access(1, 0, 32'h10, 0, 4'hF, 0, 0, n, r, to);
        total++; if (r !== exp) begin bad++; $display("FAIL both_nowrite got=%h exp=%h", r, exp); end
    endtask

    task automatic test_reset_mid;
        int n; logic [31:0] r, exp; bit to;
        exp = m_read(32'h20);
        wr = 1; addr = 32'h20; wdata = 32'h77777777; be_sig = 4'hF;
        @(posedge clk); #1;
        wr = 0; rst_n = 0;
        #1;
        total++; if (waitreq !== 1'b0 || perr !== 1'b0) begin bad++; $display("FAIL rstmid_out waitreq=%b perr=%b exp=0/0", waitreq, perr); end
        @(posedge clk); #1;
        rst_n = 1; mptr = 0; mwrap = 0;
        @(posedge clk); #1;
        access(1, 0, 32'h20, 0, 4'hF, 0, 0, n, r, to);
        total++; if (to || n != WC || r !== exp) begin bad++; $display("FAIL rstmid_word got=%h exp=%h waits=%0d", r, exp, n); end
    endtask

    task automatic test_abort;
        int n; logic [31:0] r, exp; bit to;
        exp = m_read(32'h24);
        wr = 1; addr = 32'h24; wdata = 32'h99999999;
        @(posedge clk); #1;
        wr = 0;
        @(posedge clk); #1;
        total++; if (perr !== 1'b1) begin bad++; $display("FAIL abort_perr got=%b exp=1", perr); end
        access(1, 0, 32'h24, 0, 4'hF, 0, 0, n, r, to);
        total++; if (to || n != WC || r !== exp) begin bad++; $display("FAIL abort_word got=%h exp=%h waits=%0d", r, exp, n); end
    endtask

`ifdef AVS_SAMPLE_BUFFER_BYTEENABLE_EN
    task automatic test_byteenable;
        int n; logic [31:0] r; bit to;
        access(0, 1, 32'h30, 32'hFFFFFFFF, 4'hF, 0, 0, n, r, to);
        access(0, 1, 32'h30, 32'h00000000, 4'b0101, 0, 0, n, r, to);
        m_write(32'h30, 32'hFFFFFFFF, 4'hF); m_write(32'h30, 32'h0, 4'b0101);
        access(1, 0, 32'h30, 0, 4'hF, 0, 0, n, r, to);
        total++; if (r !== 32'hFF00FF00 || r !== m_read(32'h30)) begin bad++; $display("FAIL byteenable got=%h exp=ff00ff00", r); end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_random;
        test_fill_wrap;
        test_collision;
        test_oor;
        test_both;
        test_reset_mid;
        test_abort;
`ifdef AVS_SAMPLE_BUFFER_BYTEENABLE_EN
        test_byteenable;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
